// File: rtl/reaction_pkg.sv
// Shared constants for the reaction-time game: clock rate, timer ceiling,
// derived prescaler length, timer width and the LFSR step function.
package reaction_pkg;

   localparam int          CLK_HZ       = 50_000_000;
   localparam int          MAX_MS       = 2047;
   localparam int          TICKS_PER_MS = CLK_HZ / 1000;
   localparam int          TIMER_W      = $clog2(MAX_MS);
   localparam int          MIN_DELAY_MS = 1000;
   localparam logic [15:0] LFSR_SEED    = 16'hACE1;

   // 16-bit Fibonacci step, taps 16,14,13,11, shifting towards the MSB.
   function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/ms_timer_if.sv
// Control/status bundle between the reaction-time FSM (master) and ms_timer (slave).
interface ms_timer_if
   import reaction_pkg::*;
#(
   parameter int W = TIMER_W
);

   // Master drives timer_reset/up/enable as plain levels sampled every clock;
   // slave returns registered status; ms_tick and expired are one-cycle pulses.
   logic         timer_reset;
   logic         up;
   logic         enable;
   logic [W-1:0] timer_value;
   logic         ms_tick;
   logic         expired;
   logic         saturated;

   modport master (
      output timer_reset,
      output up,
      output enable,
      input  timer_value,
      input  ms_tick,
      input  expired,
      input  saturated
   );

   modport slave (
      input  timer_reset,
      input  up,
      input  enable,
      output timer_value,
      output ms_tick,
      output expired,
      output saturated
   );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances every clock, seeded on reset.
module lfsr16
   import reaction_pkg::*;
#(
   parameter logic [15:0] SEED = reaction_pkg::LFSR_SEED
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= SEED;
      end else begin
         q <= lfsr16_next(q);
      end
   end

endmodule

// File: rtl/ms_timer.sv
// Millisecond timer: prescaler producing a 1 ms tick, and a saturating
// up/down ms counter with a random-delay load for the down direction.
module ms_timer
   import reaction_pkg::*;
#(
   parameter int          CLK_HZ       = reaction_pkg::CLK_HZ,
   parameter int          MAX_MS       = reaction_pkg::MAX_MS,
   parameter int          MIN_DELAY_MS = reaction_pkg::MIN_DELAY_MS,
   parameter logic [15:0] LFSR_SEED    = reaction_pkg::LFSR_SEED
) (
   input  logic     clk,
   input  logic     rst,
   ms_timer_if.slave bus
);

   localparam int W     = $clog2(MAX_MS);
   localparam int TICKS = CLK_HZ / 1000;
   localparam int PW    = (TICKS > 1) ? $clog2(TICKS) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS - 1);
   localparam logic [W-1:0]  MAX_V      = W'(MAX_MS);
   localparam logic [W-1:0]  MIN_V      = W'(MIN_DELAY_MS);

   if (MIN_DELAY_MS + 2 ** (W - 1) - 1 > MAX_MS) begin : g_bad_delay_range
      $error("ms_timer: MIN_DELAY_MS + 2**(W-1) - 1 exceeds MAX_MS");
   end
   if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("ms_timer: LFSR_SEED must be non-zero");
   end
   if (TICKS < 2) begin : g_bad_clk
      $error("ms_timer: CLK_HZ must give at least two clocks per ms");
   end

   logic [15:0]   lfsr_q;
   logic [PW-1:0] presc_q, presc_d;
   logic [W-1:0]  value_q, value_d;
   logic          expired_q, expired_d;
   logic          tick;
   logic [W-1:0]  load_v;
   logic          lfsr_unused;

   lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr_q)
   );

   // Only the low W-1 bits feed the random delay; the rest just keep the sequence long.
   assign lfsr_unused = ^lfsr_q[15:W-1];
   assign load_v      = MIN_V + {1'b0, lfsr_q[W-2:0]};
   assign tick        = (presc_q == PRESC_LAST);

   always_comb begin
      presc_d   = presc_q;
      value_d   = value_q;
      expired_d = 1'b0;
      if (bus.timer_reset) begin
         presc_d = '0;
         value_d = bus.up ? '0 : load_v;
      end else begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (bus.enable && tick) begin
            if (bus.up) begin
               if (value_q < MAX_V) value_d = value_q + W'(1);
            end else if (value_q != '0) begin
               value_d   = value_q - W'(1);
               expired_d = (value_q == W'(1));
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q   <= '0;
         value_q   <= '0;
         expired_q <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         value_q   <= value_d;
         expired_q <= expired_d;
      end
   end

   // All status outputs derive from registers only, so inputs reach them one clock later.
   assign bus.timer_value = value_q;
   assign bus.ms_tick     = tick;
   assign bus.expired     = expired_q;
   assign bus.saturated   = (value_q == MAX_V);

endmodule

// File: doc/ms_timer.md
MS_TIMER -- requirements
Module: ms_timer

Interface
REQ-001 Parameters SHALL be:
- CLK_HZ, default 50_000_000, system clock frequency.
- MAX_MS, default 2047, timer ceiling in ms.
- MIN_DELAY_MS, default 1000, minimum random delay.
- LFSR_SEED, default 16'hACE1, non-zero LFSR reset value.

REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 timer_reset  input  1  synchronous clear/load request from the reaction-time FSM.
REQ-006 up  input  1  count direction: 1 = up, 0 = down.
REQ-007 enable  input  1  counting permitted on ms ticks.
REQ-008 timer_value  output  $clog2(MAX_MS) (W)  current ms count, registered.
REQ-009 ms_tick  output  1  single-cycle pulse once every 1 ms.
REQ-010 expired  output  1  single-cycle pulse when a down-count reaches 0.
REQ-011 saturated  output  1  level; high while timer_value == MAX_MS.

Function
REQ-012 The prescaler SHALL count 0..TICKS_PER_MS-1, with TICKS_PER_MS = CLK_HZ/1000.
REQ-013 ms_tick SHALL assert for the one cycle in which the prescaler equals TICKS_PER_MS-1; the prescaler then wraps to 0.
REQ-014 timer_reset=1 SHALL clear the prescaler to 0, so the first count occurs a full TICKS_PER_MS cycles after timer_reset deasserts.
REQ-015 timer_reset=1 with up=1 SHALL load timer_value=0 on the next edge.
REQ-016 timer_reset=1 with up=0 SHALL load timer_value = MIN_DELAY_MS + lfsr[W-2:0] on the next edge.
REQ-017 timer_reset SHALL take priority over enable and ms_tick in the same cycle.
REQ-018 On a cycle with enable=1, ms_tick=1 and timer_reset=0:
- up=1: increment, holding at MAX_MS (saturate, no wrap).
- up=0: decrement, holding at 0 (no wrap).
REQ-019 With enable=0, timer_value SHALL hold; the prescaler SHALL keep running.
REQ-020 expired SHALL pulse exactly one cycle, on the edge where timer_value transitions 1 -> 0 while counting down; holding at 0 SHALL NOT re-pulse.
REQ-021 A direction change mid-count SHALL take effect on the next ms_tick, with no value jump.
REQ-022 A load to 0 via timer_reset SHALL NOT raise expired.
REQ-023 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, advancing every clock regardless of other inputs.
REQ-024 Elaboration SHALL fail if MIN_DELAY_MS + 2**(W-1) - 1 > MAX_MS, or if LFSR_SEED == 0.
REQ-025 Latency: every control input SHALL affect outputs exactly one clock later.
- No combinational path from any input to any output.

Reset
REQ-026 While rst=1, all of the following SHALL hold, independent of clk:
- timer_value = 0.
- prescaler = 0.
- ms_tick = 0, expired = 0, saturated = 0.
- LFSR = LFSR_SEED.
REQ-027 Reset asserted mid-count SHALL abort the count immediately; after deassertion the block SHALL behave as freshly powered-up.

Structure
REQ-028 Package reaction_pkg SHALL hold MAX_MS, CLK_HZ, derived TICKS_PER_MS, and localparam TIMER_W = $clog2(MAX_MS), shared with the FSM and display blocks.
REQ-029 The LFSR SHALL be a separate sub-module, lfsr16, with ports clk, rst and q[15:0].
REQ-030 The prescaler and counter SHALL live in ms_timer itself.

Verification (bench overrides CLK_HZ=4000, so TICKS_PER_MS=4)
REQ-031 Free-run check:
- Stimulus: rst pulse, then 40 clocks idle.
- Response: ms_tick every 4th cycle (10 pulses); timer_value stays 0.
REQ-032 Up-count and saturation:
- Stimulus: timer_reset with up=1, then enable=1, up=1 for 2050 ms.
- Response: timer_value reaches 2047 at ms 2047 and holds; saturated=1 from that cycle.
REQ-033 Random load and expiry:
- Stimulus: timer_reset with up=0.
- Response: loaded value lies in 1000..2023 and equals 1000 + the model LFSR low 10 bits.
- Stimulus: then enable=1, up=0.
- Response: decrements once per tick; expired pulses once at 0; value holds 0 with no further pulses.
REQ-034 Priority:
- Stimulus: timer_reset and ms_tick coincident while counting up from 500.
- Response: value = 0 next edge; next increment exactly 4 cycles after timer_reset drops.
REQ-035 Reset mid-operation:
- Stimulus: assert rst mid-clock at timer_value=300.
- Response: all outputs 0 before the next edge; LFSR restarts from 16'hACE1.
REQ-036 Enable gating:
- Stimulus: toggle enable low for 10 ms during an up-count at 100.
- Response: value frozen at 100 throughout; ms_tick continues.
